// File: rtl/mcpu_pkg.sv
// Shared types and constants for the CPU/loader memory arbiter.
package mcpu_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StQuiesce = 2'd1,
    StGrant   = 2'd2,
    StRelease = 2'd3
  } arb_state_e;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 8;

  // Memory and CPU strobes are active-low.
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/mcpu_bus_mux.sv
// Combinational memory-bus steering between the CPU port and the loader port.
module mcpu_bus_mux
  import mcpu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  arb_state_e        state,
  input  logic [ADDR_W-1:0] cpu_adress,
  input  logic [DATA_W-1:0] cpu_dataO,
  input  logic              cpu_oe,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_data,
  input  logic              ld_req,
  input  logic              ld_valid,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [ADDR_W-1:0] mem_adress,
  output logic [DATA_W-1:0] mem_dataO,
  output logic              mem_oe,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data
);

  logic ld_beat;
  assign ld_beat = ld_valid & ld_req;

  // Select bus owner by arbiter state; idle bus in QUIESCE and RELEASE.
  always_comb begin
    mem_adress = '0;
    mem_dataO  = '0;
    mem_oe     = STROBE_OFF;
    mem_we     = STROBE_OFF;
    cpu_data   = '0;
    unique case (state)
      StRun: begin
        mem_adress = cpu_adress;
        mem_dataO  = cpu_dataO;
        mem_oe     = cpu_oe;
        mem_we     = cpu_we;
        cpu_data   = mem_data;
      end
      StGrant: begin
        mem_adress = ld_addr;
        mem_dataO  = ld_wdata;
        mem_we     = (ld_beat & ld_we) ? STROBE_ON : STROBE_OFF;
        mem_oe     = (ld_beat & ~ld_we) ? STROBE_ON : STROBE_OFF;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mcpu_mem_arb.sv
// Memory arbiter: holds the CPU in reset and hands the memory bus to a loader.
module mcpu_mem_arb
  import mcpu_pkg::*;
#(
  parameter int unsigned QUIESCE_CYC = 2,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_adress,
  input  logic [DATA_W-1:0] cpu_dataO,
  input  logic              cpu_oe,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_rst,
  input  logic              ld_req,
  input  logic              ld_valid,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_ready,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  output logic [ADDR_W-1:0] mem_adress,
  output logic [DATA_W-1:0] mem_dataO,
  output logic              mem_oe,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data,
  output logic [7:0]        xfer_cnt
);

  localparam logic [3:0] QcntLoad = 4'(QUIESCE_CYC - 1);

  arb_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        xfer_q, xfer_d;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              beat_acc;
  logic              rd_acc;

  assign ld_gnt    = (state_q == StGrant);
  assign ld_ready  = ld_gnt & ld_req;
  assign beat_acc  = ld_ready & ld_valid;
  assign rd_acc    = beat_acc & ~ld_we;
  // CPU reset follows the block reset combinationally, not just via state.
  assign cpu_rst   = rst & (state_q == StRun);
  assign xfer_cnt  = xfer_q;
  assign ld_rdata  = rdata_q;
  assign ld_rvalid = rvalid_q;

  // Next-state, quiesce countdown and beat counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xfer_d  = xfer_q;
    unique case (state_q)
      StRun: begin
        if (ld_req) begin
          state_d = StQuiesce;
          cnt_d   = QcntLoad;
          xfer_d  = '0;
        end
      end
      StQuiesce: begin
        // A dropped request does not abort the quiesce window.
        if (cnt_q == 4'd0) state_d = StGrant;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StGrant: begin
        if (!ld_req) state_d = StRelease;
        if (beat_acc) xfer_d = xfer_q + 8'd1;
      end
      StRelease: state_d = StRun;
      default:   state_d = StRun;
    endcase
  end

  // State, counters and loader read-data register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StRun;
      cnt_q    <= '0;
      xfer_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xfer_q   <= xfer_d;
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= mem_data;
    end
  end

  mcpu_bus_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_bus_mux (
    .state      (state_q),
    .cpu_adress (cpu_adress),
    .cpu_dataO  (cpu_dataO),
    .cpu_oe     (cpu_oe),
    .cpu_we     (cpu_we),
    .cpu_data   (cpu_data),
    .ld_req     (ld_req),
    .ld_valid   (ld_valid),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .mem_adress (mem_adress),
    .mem_dataO  (mem_dataO),
    .mem_oe     (mem_oe),
    .mem_we     (mem_we),
    .mem_data   (mem_data)
  );

endmodule

// File: tb/tb_mcpu_mem_arb.sv
// Directed self-checking bench for mcpu_mem_arb with a loader read scoreboard.
module tb_mcpu_mem_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] cpu_adress;
  logic [7:0] cpu_dataO;
  logic       cpu_oe, cpu_we;
  logic [7:0] cpu_data;
  logic       cpu_rst;
  logic       ld_req, ld_valid, ld_we;
  logic [5:0] ld_addr;
  logic [7:0] ld_wdata;
  logic       ld_gnt, ld_ready;
  logic [7:0] ld_rdata;
  logic       ld_rvalid;
  logic [5:0] mem_adress;
  logic [7:0] mem_dataO;
  logic       mem_oe, mem_we;
  logic [7:0] mem_data;
  logic [7:0] xfer_cnt;

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mem [64];

  always #5 clk = ~clk;

  mcpu_mem_arb dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_adress (cpu_adress),
    .cpu_dataO  (cpu_dataO),
    .cpu_oe     (cpu_oe),
    .cpu_we     (cpu_we),
    .cpu_data   (cpu_data),
    .cpu_rst    (cpu_rst),
    .ld_req     (ld_req),
    .ld_valid   (ld_valid),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .ld_gnt     (ld_gnt),
    .ld_ready   (ld_ready),
    .ld_rdata   (ld_rdata),
    .ld_rvalid  (ld_rvalid),
    .mem_adress (mem_adress),
    .mem_dataO  (mem_dataO),
    .mem_oe     (mem_oe),
    .mem_we     (mem_we),
    .mem_data   (mem_data),
    .xfer_cnt   (xfer_cnt)
  );

  // Simple memory model: async read, write on clock edge.
  assign mem_data = mem[mem_adress];
  always @(posedge clk) if (mem_we === 1'b0) mem[mem_adress] <= mem_dataO;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every loader read data beat must match the oldest expected value.
  always @(negedge clk) begin
    if (ld_rvalid === 1'b1) begin
      if (exp_q.size() == 0) chk("rvalid_unexpected", 32'(ld_rvalid), 32'd0);
      else chk("sb_rdata", 32'(ld_rdata), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[6'h15] = 8'hA5;
    rst = 1'b0; ld_req = 1'b0; ld_valid = 1'b0; ld_we = 1'b0;
    ld_addr = '0; ld_wdata = '0;
    cpu_adress = '0; cpu_dataO = '0; cpu_oe = 1'b1; cpu_we = 1'b1;

    // Reset values
    tick(); tick(); #1;
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("rst_xfer", 32'(xfer_cnt), 32'd0);
    chk("rst_rvalid", 32'(ld_rvalid), 32'd0);
    chk("rst_rdata", 32'(ld_rdata), 32'd0);
    chk("rst_gnt", 32'(ld_gnt), 32'd0);

    // Idle RUN pass-through
    rst = 1'b1; tick();
    cpu_adress = 6'h15; cpu_oe = 1'b0; #1;
    chk("run_addr", 32'(mem_adress), 32'h15);
    chk("run_oe", 32'(mem_oe), 32'd0);
    chk("run_we", 32'(mem_we), 32'd1);
    chk("run_cpu_data", 32'(cpu_data), 32'hA5);
    chk("run_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("run_ready", 32'(ld_ready), 32'd0);

    // Request: quiesce for two cycles, then grant
    cpu_oe = 1'b1; cpu_we = 1'b0; cpu_dataO = 8'h77; ld_req = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick(); #1;
      chk("q_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("q_gnt", 32'(ld_gnt), 32'd0);
      chk("q_we", 32'(mem_we), 32'd1);
      chk("q_oe", 32'(mem_oe), 32'd1);
      chk("q_addr", 32'(mem_adress), 32'd0);
      chk("q_cpu_data", 32'(cpu_data), 32'd0);
      chk("q_xfer", 32'(xfer_cnt), 32'd0);
    end
    cpu_we = 1'b1;
    tick(); #1;
    chk("g_gnt", 32'(ld_gnt), 32'd1);
    chk("g_ready", 32'(ld_ready), 32'd1);
    chk("g_cpu_rst", 32'(cpu_rst), 32'd0);

    // Write beats 0x00..0x3F, data = addr ^ 0xFF
    for (int a = 0; a < 64; a++) begin
      ld_valid = 1'b1; ld_we = 1'b1; ld_addr = 6'(a); ld_wdata = 8'(a) ^ 8'hFF; #1;
      chk("wr_we", 32'(mem_we), 32'd0);
      chk("wr_addr", 32'(mem_adress), 32'(a));
      tick();
    end
    ld_we = 1'b0; ld_addr = 6'h2A; #1;
    chk("rd_oe", 32'(mem_oe), 32'd0);
    exp_q.push_back(8'hD5);
    tick(); ld_valid = 1'b0; #1;
    chk("rd_rvalid", 32'(ld_rvalid), 32'd1);
    chk("rd_rdata", 32'(ld_rdata), 32'hD5);
    chk("xfer_65", 32'(xfer_cnt), 32'd65);
    tick(); #1;
    chk("rd_rvalid_drop", 32'(ld_rvalid), 32'd0);

    // Read on last granted cycle, then request drops
    ld_valid = 1'b1; ld_we = 1'b0; ld_addr = 6'h10;
    exp_q.push_back(8'hEF);
    tick(); ld_req = 1'b0; #1;
    chk("drop_ready", 32'(ld_ready), 32'd0);
    chk("drop_oe", 32'(mem_oe), 32'd1);
    chk("drop_rvalid", 32'(ld_rvalid), 32'd1);
    tick(); ld_valid = 1'b0; ld_req = 1'b1; #1;
    chk("rel_gnt", 32'(ld_gnt), 32'd0);
    chk("rel_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("rel_oe", 32'(mem_oe), 32'd1);
    chk("rel_xfer", 32'(xfer_cnt), 32'd66);
    tick(); #1;
    chk("ret_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("ret_gnt", 32'(ld_gnt), 32'd0);
    tick(); #1;
    chk("req2_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("req2_xfer_clr", 32'(xfer_cnt), 32'd0);
    tick(); tick(); #1;
    chk("req2_gnt", 32'(ld_gnt), 32'd1);

    // Reset mid-grant with a read beat pending
    ld_valid = 1'b1; ld_we = 1'b0; ld_addr = 6'h05; rst = 1'b0; #1;
    chk("rstg_cpu_rst", 32'(cpu_rst), 32'd0);
    tick(); ld_valid = 1'b0; #1;
    chk("rstg_gnt", 32'(ld_gnt), 32'd0);
    chk("rstg_rvalid", 32'(ld_rvalid), 32'd0);
    chk("rstg_xfer", 32'(xfer_cnt), 32'd0);
    chk("rstg_cpu_rst_hold", 32'(cpu_rst), 32'd0);
    tick();
    // Request held through reset release enters quiesce on first active edge
    rst = 1'b1; #1;
    chk("rel_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    tick(); ld_req = 1'b0; #1;
    chk("held_q_cpu_rst", 32'(cpu_rst), 32'd0);
    tick(); tick(); #1;
    chk("held_g_gnt", 32'(ld_gnt), 32'd1);
    chk("held_g_ready", 32'(ld_ready), 32'd0);
    tick(); tick(); #1;
    chk("held_run_cpu_rst", 32'(cpu_rst), 32'd1);

    // One-cycle pulse in RUN: full quiesce, one empty grant, release, run
    ld_req = 1'b1;
    tick(); ld_req = 1'b0; #1;
    chk("pls_q1", 32'(cpu_rst), 32'd0);
    tick(); #1;
    chk("pls_q2_gnt", 32'(ld_gnt), 32'd0);
    tick(); #1;
    chk("pls_g_gnt", 32'(ld_gnt), 32'd1);
    chk("pls_g_ready", 32'(ld_ready), 32'd0);
    tick(); #1;
    chk("pls_rel_gnt", 32'(ld_gnt), 32'd0);
    chk("pls_rel_cpu_rst", 32'(cpu_rst), 32'd0);
    tick(); #1;
    chk("pls_run_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("pls_xfer", 32'(xfer_cnt), 32'd0);

    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
